// File: rtl/time_edit_controller_pkg.sv
// Shared clock constants for the time-edit controller.
// Holds the edit FSM state encoding, the one-hot cursor field codes, the
// button index map used by the debouncer array, and small helpers that map
// a state to its cursor code and to the state reached on a mode press.
package time_edit_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        EDIT_SEC = 2'd3
    } editState_t;

    localparam logic [2:0] CURSOR_NONE = 3'b000;
    localparam logic [2:0] CURSOR_HR   = 3'b100;
    localparam logic [2:0] CURSOR_MIN  = 3'b010;
    localparam logic [2:0] CURSOR_SEC  = 3'b001;

    // Button lanes of the debouncer array
    localparam int NUM_BTNS  = 4;
    localparam int BTN_MODE  = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_CLEAR = 3;

    function automatic logic [2:0] cursorOf(input editState_t s);
        case (s)
            EDIT_HR:  return CURSOR_HR;
            EDIT_MIN: return CURSOR_MIN;
            EDIT_SEC: return CURSOR_SEC;
            default:  return CURSOR_NONE;
        endcase
    endfunction

    function automatic editState_t advanceState(input editState_t s);
        case (s)
            RUN:      return EDIT_HR;
            EDIT_HR:  return EDIT_MIN;
            EDIT_MIN: return EDIT_SEC;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button front end: 2-flop synchronizer, counting debouncer and
// rising-edge press detector.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   btnRaw      - raw asynchronous button, active-high
//   level       - debounced button level
//   press       - one-cycle pulse the cycle after level goes 0->1
// After reset the debouncer is disarmed: it must first see the button
// stably released (DEBOUNCE_CYC low samples) before a level rise can
// happen, so a button held through reset never produces a press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       syncQ;
    logic             armed;
    logic             levelQ;
    logic             levelD;
    logic [CNT_W-1:0] cnt;
    logic             pending;

    // While disarmed the button is treated as if held, so only a run of
    // low samples makes progress (and arms instead of moving the level).
    assign pending = armed ? (syncQ[1] != levelQ) : ~syncQ[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ  <= 2'b00;
            armed  <= 1'b0;
            levelQ <= 1'b0;
            levelD <= 1'b0;
            cnt    <= '0;
        end else begin
            syncQ  <= {syncQ[0], btnRaw};
            levelD <= levelQ;
            if (!pending) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (armed) levelQ <= syncQ[1];
                else       armed  <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = levelQ;
    assign press = levelQ & ~levelD;

endmodule

// File: rtl/time_edit_controller.sv
// Time-edit controller: turns four push-buttons into edit-mode navigation
// and single-cycle up/down/clear commands for the time storage block.
// Ports:
//   clk, reset                              - clock, synchronous active-high reset
//   btn_mode, btn_up, btn_down, btn_clear   - raw asynchronous buttons
//   up, down, clr                           - one-cycle command pulses
//   cursor_pos                              - one-hot field select (hr/min/sec)
//   editing                                 - high in any edit state
//   blink                                   - blank strobe for the selected field
// Holding up/down in an edit state auto-repeats; an edit state with no
// button activity for TIMEOUT_CYC cycles falls back to RUN.
module time_edit_controller
    import time_edit_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
    parameter logic [31:0] TIMEOUT_CYC      = 32'd3_000_000_000,
    parameter int unsigned BLINK_CYC        = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clear,
    output logic       up,
    output logic       down,
    output logic       clr,
    output logic [2:0] cursor_pos,
    output logic       editing,
    output logic       blink
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE_CYC - 1);
    localparam int unsigned BLK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BLK_W-1:0] BLINK_LAST     = BLK_W'(BLINK_CYC - 1);
    localparam logic [31:0]      TIMEOUT_LAST   = TIMEOUT_CYC - 32'd1;

    logic [NUM_BTNS-1:0] btnRaw;
    logic [NUM_BTNS-1:0] btnLevel;
    logic [NUM_BTNS-1:0] btnPress;
    logic                unusedLevels;

    editState_t state, nextState;
    logic       inEdit, bothHeld;
    logic       upPressEvt, downPressEvt, repFire, upEvt, downEvt;
    logic       anyEvt, timeoutHit;
    logic       holdUp, holdDown, repFast;
    logic [REP_W-1:0] repCnt;
    logic [31:0]      toCnt;
    logic [BLK_W-1:0] blinkCnt;

    assign btnRaw = {btn_clear, btn_down, btn_up, btn_mode};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : gBtn
        button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) uDeb (
            .clk    (clk),
            .reset  (reset),
            .btnRaw (btnRaw[i]),
            .level  (btnLevel[i]),
            .press  (btnPress[i])
        );
    end

    // Only the up/down levels matter; mode and clear act on presses alone.
    assign unusedLevels = btnLevel[BTN_MODE] ^ btnLevel[BTN_CLEAR];

    always_comb begin
        inEdit       = (state != RUN);
        bothHeld     = btnLevel[BTN_UP] & btnLevel[BTN_DOWN];
        upPressEvt   = inEdit & btnPress[BTN_UP]   & ~btnLevel[BTN_DOWN];
        downPressEvt = inEdit & btnPress[BTN_DOWN] & ~btnLevel[BTN_UP];
        // Repeat needs the same button still down; a mode press in the same
        // cycle is a state change and cancels the repeat.
        repFire      = inEdit & ~bothHeld & ~btnPress[BTN_MODE]
                     & ((holdUp & btnLevel[BTN_UP]) | (holdDown & btnLevel[BTN_DOWN]))
                     & (repCnt == (repFast ? REP_RATE_LAST : REP_DELAY_LAST));
        upEvt        = upPressEvt   | (repFire & holdUp);
        downEvt      = downPressEvt | (repFire & holdDown);
        anyEvt       = (|btnPress) | repFire;
        timeoutHit   = inEdit & ~anyEvt & (toCnt == TIMEOUT_LAST);

        nextState = state;
        if (btnPress[BTN_MODE])  nextState = advanceState(state);
        else if (timeoutHit)     nextState = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            cursor_pos <= CURSOR_NONE;
        end else begin
            state      <= nextState;
            cursor_pos <= cursorOf(nextState);
        end
    end

    assign editing = (state != RUN);

    // Auto-repeat tracker: which button owns the repeat, and the cycle count
    // toward the first (delay) or subsequent (rate) repeat.
    always_ff @(posedge clk) begin
        if (reset || (nextState != state) || !inEdit || bothHeld) begin
            holdUp   <= 1'b0;
            holdDown <= 1'b0;
            repFast  <= 1'b0;
            repCnt   <= '0;
        end else if (upPressEvt || downPressEvt) begin
            holdUp   <= upPressEvt;
            holdDown <= downPressEvt;
            repFast  <= 1'b0;
            repCnt   <= '0;
        end else if ((holdUp & ~btnLevel[BTN_UP]) | (holdDown & ~btnLevel[BTN_DOWN])) begin
            holdUp   <= 1'b0;
            holdDown <= 1'b0;
            repFast  <= 1'b0;
            repCnt   <= '0;
        end else if (repFire) begin
            repFast  <= 1'b1;
            repCnt   <= '0;
        end else if (holdUp || holdDown) begin
            repCnt   <= repCnt + REP_W'(1);
        end
    end

    // Self-masking keeps every command pulse strictly one cycle wide.
    always_ff @(posedge clk) begin
        if (reset) begin
            up   <= 1'b0;
            down <= 1'b0;
            clr  <= 1'b0;
        end else begin
            up   <= upEvt & ~up;
            down <= downEvt & ~down;
            clr  <= btnPress[BTN_CLEAR] & ~clr;
        end
    end

    // Inactivity timer: held at zero in RUN and on edit entry, reloaded on
    // every press or repeat.
    always_ff @(posedge clk) begin
        if (reset || (nextState == RUN) || anyEvt || (state == RUN)) begin
            toCnt <= '0;
        end else begin
            toCnt <= toCnt + 32'd1;
        end
    end

    // Blink phase restarts low whenever edit mode is entered from RUN and
    // runs continuously while moving between fields.
    always_ff @(posedge clk) begin
        if (reset || (nextState == RUN) || (state == RUN)) begin
            blinkCnt <= '0;
            blink    <= 1'b0;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blink    <= ~blink;
        end else begin
            blinkCnt <= blinkCnt + BLK_W'(1);
        end
    end

endmodule
